// File: rtl/simmem_releaser.sv
// Delay-slot releaser: holds requests for a programmed number of cycles, then counts
// them as ripe per ID and enables the linked-list bank to release that ID.
module simmem_releaser #(
    parameter int IDWidth      = 4,
    parameter int NumSlots     = 8,
    parameter int DelayWidth   = 8,
    parameter int RipeCntWidth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [IDWidth-1:0]      req_id_i,
    input  logic [DelayWidth-1:0]   req_delay_i,
    output logic [2**IDWidth-1:0]   release_en_o,
    input  logic                    rsp_released_i,
    input  logic [IDWidth-1:0]      rsp_released_id_i
);
    localparam int NumIds = 2**IDWidth;
    localparam int SlotW  = (NumSlots > 1) ? $clog2(NumSlots) : 1;
    localparam logic [RipeCntWidth-1:0] RipeMax = '1;

    logic [NumSlots-1:0]                 slot_vld_q, slot_vld_d;
    logic [NumSlots-1:0][IDWidth-1:0]    slot_id_q, slot_id_d;
    logic [NumSlots-1:0][DelayWidth-1:0] slot_cnt_q, slot_cnt_d;
    logic [NumIds-1:0][RipeCntWidth-1:0] ripe_q, ripe_d;
    logic [SlotW-1:0]                    free_idx;

    assign req_ready_o = ~&slot_vld_q;

    always_comb begin
        free_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!slot_vld_q[i]) free_idx = SlotW'(i);
        end
    end

    // The release is applied first so that it frees headroom for a retirement in the
    // same cycle; slots are then scanned low to high so lower indices win headroom.
    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_id_d  = slot_id_q;
        slot_cnt_d = slot_cnt_q;
        ripe_d     = ripe_q;

        if (rsp_released_i && ripe_q[rsp_released_id_i] != '0)
            ripe_d[rsp_released_id_i] = ripe_q[rsp_released_id_i] - 1'b1;

        for (int i = 0; i < NumSlots; i++) begin
            if (slot_vld_q[i]) begin
                if (slot_cnt_q[i] != '0) begin
                    slot_cnt_d[i] = slot_cnt_q[i] - 1'b1;
                end else if (ripe_d[slot_id_q[i]] != RipeMax) begin
                    ripe_d[slot_id_q[i]] = ripe_d[slot_id_q[i]] + 1'b1;
                    slot_vld_d[i]        = 1'b0;
                end
            end
        end

        // free_idx points at a slot invalid in the registered state, so it never
        // collides with a retirement above.
        if (req_valid_i && req_ready_o) begin
            slot_vld_d[free_idx] = 1'b1;
            slot_id_d[free_idx]  = req_id_i;
            slot_cnt_d[free_idx] = req_delay_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_vld_q <= '0;
            slot_id_q  <= '0;
            slot_cnt_q <= '0;
            ripe_q     <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            slot_id_q  <= slot_id_d;
            slot_cnt_q <= slot_cnt_d;
            ripe_q     <= ripe_d;
        end
    end

    for (genvar g = 0; g < NumIds; g++) begin : g_en
        assign release_en_o[g] = (ripe_q[g] != '0);
    end

endmodule

// File: tb/tb_simmem_releaser.sv
// Directed bench for simmem_releaser: a cycle table for the basic flows plus
// hand sequences for slot exhaustion, ripe-counter saturation and mid-run reset.
module tb_simmem_releaser;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_id;
    logic [7:0]  req_delay;
    logic [15:0] release_en;
    logic        rsp_released;
    logic [3:0]  rsp_released_id;

    int checks = 0;
    int errors = 0;

    simmem_releaser #(
        .IDWidth(4), .NumSlots(8), .DelayWidth(8), .RipeCntWidth(4)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_id_i          (req_id),
        .req_delay_i       (req_delay),
        .release_en_o      (release_en),
        .rsp_released_i    (rsp_released),
        .rsp_released_id_i (rsp_released_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [3:0]  id;
        logic [7:0]  dly;
        logic        rel;
        logic [3:0]  rid;
        logic        rdy;
        logic [15:0] en;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, take the edge, sample 1 time unit later.
    task automatic step(input logic v, input logic [3:0] id, input logic [7:0] d,
                        input logic r, input logic [3:0] rid);
        req_valid       = v;
        req_id          = id;
        req_delay       = d;
        rsp_released    = r;
        rsp_released_id = rid;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 8'd0, 1'b0, 4'd0);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ready", 16'(req_ready), 16'h0001);
        chk("reset_en", release_en, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // vld id dly rel rid | rdy en  (outputs sampled after that cycle's edge)
        tbl[0]  = '{1'b1, 4'd2, 8'd3, 1'b0, 4'd0, 1'b1, 16'h0000}; // accept id2 d3
        tbl[1]  = '{1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0000};
        tbl[2]  = '{1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0000};
        tbl[3]  = '{1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0000};
        tbl[4]  = '{1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0004}; // retire at N+D+1
        tbl[5]  = '{1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0004};
        tbl[6]  = '{1'b0, 4'd0, 8'd0, 1'b1, 4'd2, 1'b1, 16'h0000}; // release id2
        tbl[7]  = '{1'b1, 4'd5, 8'd1, 1'b0, 4'd0, 1'b1, 16'h0000}; // id5 d1
        tbl[8]  = '{1'b1, 4'd5, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0000}; // id5 d0, same retire edge
        tbl[9]  = '{1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0020}; // ripe[5]=2
        tbl[10] = '{1'b0, 4'd0, 8'd0, 1'b1, 4'd5, 1'b1, 16'h0020}; // ripe[5]=1
        tbl[11] = '{1'b0, 4'd0, 8'd0, 1'b1, 4'd5, 1'b1, 16'h0000}; // ripe[5]=0
        tbl[12] = '{1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0000};
        tbl[13] = '{1'b1, 4'd1, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0000}; // id1 d0
        tbl[14] = '{1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0002}; // ripe[1]=1
        tbl[15] = '{1'b1, 4'd1, 8'd1, 1'b0, 4'd0, 1'b1, 16'h0002}; // id1 d1 -> retire edge 17
        tbl[16] = '{1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0002};
        tbl[17] = '{1'b0, 4'd0, 8'd0, 1'b1, 4'd1, 1'b1, 16'h0002}; // retire+release: stays 1
        tbl[18] = '{1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0002};
        tbl[19] = '{1'b0, 4'd0, 8'd0, 1'b1, 4'd1, 1'b1, 16'h0000};
        tbl[20] = '{1'b0, 4'd0, 8'd0, 1'b1, 4'd7, 1'b1, 16'h0000}; // release at 0: floor
        tbl[21] = '{1'b1, 4'd7, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0000};
        tbl[22] = '{1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 16'h0080}; // ripe[7]=1
        tbl[23] = '{1'b0, 4'd0, 8'd0, 1'b1, 4'd7, 1'b1, 16'h0000}; // ripe[7]=0

        rst_n = 1'b0;
        req_valid = 1'b0; req_id = '0; req_delay = '0;
        rsp_released = 1'b0; rsp_released_id = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_ready", 16'(req_ready), 16'h0001);
        chk("init_en", release_en, 16'h0000);
        rst_n = 1'b1;

        for (int k = 0; k < 24; k++) begin
            step(tbl[k].vld, tbl[k].id, tbl[k].dly, tbl[k].rel, tbl[k].rid);
            chk($sformatf("tbl%0d_ready", k), 16'(req_ready), 16'(tbl[k].rdy));
            chk($sformatf("tbl%0d_en", k), release_en, tbl[k].en);
        end

        // Fill all 8 slots with delay 200; first one frees at edge 201.
        reset_pulse();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'(i), 8'd200, 1'b0, 4'd0);
            chk($sformatf("fill%0d_ready", i), 16'(req_ready), (i < 7) ? 16'h0001 : 16'h0000);
        end
        for (int e = 8; e <= 200; e++) idle();
        chk("full_e200_ready", 16'(req_ready), 16'h0000);
        chk("full_e200_en", release_en, 16'h0000);
        idle();
        chk("full_e201_ready", 16'(req_ready), 16'h0001);
        chk("full_e201_en", release_en, 16'h0001);

        // 16 zero-delay requests on ID 0: 15 ripe, one slot held at counter 0.
        reset_pulse();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'd0, 8'd0, 1'b0, 4'd0);
            chk($sformatf("sat%0d_ready", i), 16'(req_ready), 16'h0001);
        end
        idle();
        chk("sat_en", release_en, 16'h0001);
        // First release lets the held slot retire; 16 releases are needed in total.
        for (int r = 0; r < 16; r++) begin
            step(1'b0, 4'd0, 8'd0, 1'b1, 4'd0);
            chk($sformatf("sat_rel%0d_en", r), release_en, (r < 15) ? 16'h0001 : 16'h0000);
        end
        idle();
        chk("sat_done_en", release_en, 16'h0000);

        // Mid-run reset with ripe[3]=2 and four delays pending.
        reset_pulse();
        step(1'b1, 4'd3, 8'd0, 1'b0, 4'd0);
        step(1'b1, 4'd3, 8'd0, 1'b0, 4'd0);
        step(1'b1, 4'd4, 8'd50, 1'b0, 4'd0);
        step(1'b1, 4'd5, 8'd50, 1'b0, 4'd0);
        step(1'b1, 4'd6, 8'd50, 1'b0, 4'd0);
        step(1'b1, 4'd7, 8'd50, 1'b0, 4'd0);
        idle();
        chk("pre_rst_en", release_en, 16'h0008);
        reset_pulse();
        begin
            int bad = 0;
            for (int c = 0; c < 300; c++) begin
                idle();
                if (release_en != 16'h0000) bad++;
            end
            chk("post_rst_quiet", 16'(bad), 16'h0000);
        end
        chk("post_rst_ready", 16'(req_ready), 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
